// File: rtl/nano_bulk_upload_if.sv
// Wishbone slave bus bundle for the bulk upload block.
// Master drives the request side, slave returns data and ack.
interface nano_bulk_upload_if;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic        wb_we_i;
  logic        wb_adr_i;
  logic [1:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;

  modport master (
    output wb_dat_i, wb_we_i, wb_adr_i,
    output wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_dat_i, wb_we_i, wb_adr_i,
    input  wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/nano_bulk_upload.sv
// CPU-to-host bulk upload over Virtual Wire.
// Fill buffer takes CPU bytes, hold buffer drives the probe.
module nano_bulk_upload #(
  parameter int FLUSH_THRESH = 31,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  nano_bulk_upload_if.slave   wb,
  output logic [255:0]        vw_bulkdata_out,
  input  logic                vw_bulkack_in
);

  localparam logic [4:0] THR  = 5'(FLUSH_THRESH);
  localparam logic [4:0] FULL = 5'd31;

  logic                   ack_q;
  logic [15:0]            dat_q, dat_d;
  logic [247:0]           fill_q, fill_d;
  logic [4:0]             cnt_q, cnt_d;
  logic                   pend_q, pend_d;
  logic                   ovf_q, ovf_d;
  logic                   strobe_q, strobe_d;
  logic [4:0]             hcnt_q, hcnt_d;
  logic [247:0]           hdat_q, hdat_d;
  logic [SYNC_STAGES-1:0] sync_q;

  logic       accept;
  logic       rd;
  logic       push;
  logic       ctrl_wr;
  logic       ack_s;
  logic       busy;
  logic       handover;
  logic [7:0] pbyte;
  logic       unused_ok;

  assign accept  = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  assign rd      = accept & ~wb.wb_we_i;
  assign push    = accept & wb.wb_we_i & ~wb.wb_adr_i
                 & wb.wb_sel_i[0];
  assign ctrl_wr = accept & wb.wb_we_i & wb.wb_adr_i;
  assign pbyte   = wb.wb_dat_i[7:0];

  assign ack_s    = sync_q[SYNC_STAGES-1];
  assign busy     = strobe_q ^ ack_s;
  assign handover = ~busy & (cnt_q != 5'd0)
                  & (pend_q | (cnt_q >= THR));

  assign unused_ok = ^{wb.wb_dat_i[15:8], wb.wb_sel_i[1]};

  assign wb.wb_ack_o     = ack_q;
  assign wb.wb_dat_o     = dat_q;
  assign vw_bulkdata_out = {strobe_q, 2'b00, hcnt_q, hdat_q};

  // Next state for buffers, flags and read data.
  always_comb begin
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    ovf_d    = ovf_q;
    strobe_d = strobe_q;
    hcnt_d   = hcnt_q;
    hdat_d   = hdat_q;
    dat_d    = dat_q;
    if (handover) begin
      hcnt_d   = cnt_q;
      hdat_d   = fill_q;
      strobe_d = ~strobe_q;
      pend_d   = 1'b0;
      fill_d   = '0;
      cnt_d    = 5'd0;
      if (push) begin
        fill_d[7:0] = pbyte;
        cnt_d       = 5'd1;
      end
    end else begin
      if (pend_q && cnt_q == 5'd0)
        pend_d = 1'b0;
      if (push) begin
        if (cnt_q != FULL) begin
          fill_d[{cnt_q, 3'b000} +: 8] = pbyte;
          cnt_d = cnt_q + 5'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
    if (ctrl_wr) begin
      if (wb.wb_dat_i[0]) pend_d = 1'b1;
      if (wb.wb_dat_i[1]) ovf_d  = 1'b0;
    end
    if (rd) begin
      if (wb.wb_adr_i)
        dat_d = {11'd0, hcnt_q};
      else
        dat_d = {busy, ovf_q, pend_q, cnt_q, 8'd0};
    end
  end

  // State registers and host ack synchroniser.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      ack_q    <= 1'b0;
      dat_q    <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
      strobe_q <= 1'b0;
      hcnt_q   <= '0;
      hdat_q   <= '0;
      sync_q   <= '0;
    end else begin
      ack_q    <= accept;
      dat_q    <= dat_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      strobe_q <= strobe_d;
      hcnt_q   <= hcnt_d;
      hdat_q   <= hdat_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], vw_bulkack_in};
    end
  end

endmodule

// File: tb/tb_nano_bulk_upload.sv
// Randomised bench for nano_bulk_upload.
// Queue-based packet model predicts status and probe data.
module tb_nano_bulk_upload;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] vw;
  logic         hack_in = 1'b0;

  nano_bulk_upload_if bus ();

  nano_bulk_upload dut (
    .wb_clk_i        (clk),
    .wb_rst_n_i      (rst_n),
    .wb              (bus),
    .vw_bulkdata_out (vw),
    .vw_bulkack_in   (hack_in)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  byte unsigned m_fill[$];
  byte unsigned m_hold[$];
  bit m_strobe, m_hack, m_ovf, m_pend;

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_fill.delete();
    m_hold.delete();
    m_strobe = 0;
    m_hack   = 0;
    m_ovf    = 0;
    m_pend   = 0;
  endfunction

  function automatic void settle();
    if (m_pend && m_fill.size() == 0) m_pend = 0;
    if (m_strobe == m_hack && m_fill.size() != 0 &&
        (m_pend || m_fill.size() >= 31)) begin
      m_hold   = m_fill;
      m_fill.delete();
      m_strobe = ~m_strobe;
      m_pend   = 0;
    end
  endfunction

  function automatic logic [255:0] exp_vw();
    logic [255:0] v;
    v = '0;
    v[255] = m_strobe;
    v[252:248] = 5'(m_hold.size());
    foreach (m_hold[i]) v[i*8 +: 8] = m_hold[i];
    return v;
  endfunction

  function automatic logic [15:0] exp_stat();
    logic [15:0] s;
    s = '0;
    s[15] = m_strobe ^ m_hack;
    s[14] = m_ovf;
    s[13] = m_pend;
    s[12:8] = 5'(m_fill.size());
    return s;
  endfunction

  task automatic bus_op(input logic we, input logic adr,
                        input logic [15:0] d,
                        input logic [1:0] sel,
                        output logic [15:0] rdat);
    @(negedge clk);
    chk("ack_idle", 256'(bus.wb_ack_o), 256'(1'b0));
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_dat_i = d;
    bus.wb_sel_i = sel;
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    @(posedge clk);
    #1;
    chk("ack_hi", 256'(bus.wb_ack_o), 256'(1'b1));
    rdat = bus.wb_dat_o;
    @(negedge clk);
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    @(posedge clk);
    #1;
    chk("ack_lo", 256'(bus.wb_ack_o), 256'(1'b0));
  endtask

  task automatic push(input byte unsigned b,
                      input logic [1:0] sel);
    logic [15:0] r;
    bus_op(1'b1, 1'b0, {8'h5a, b}, sel, r);
    if (sel[0]) begin
      if (m_fill.size() < 31) m_fill.push_back(b);
      else m_ovf = 1;
    end
    settle();
    chk("vw_push", vw, exp_vw());
  endtask

  task automatic ctrl(input logic [15:0] d);
    logic [15:0] r;
    bus_op(1'b1, 1'b1, d, 2'b11, r);
    if (d[0]) m_pend = 1;
    if (d[1]) m_ovf = 0;
    settle();
    chk("vw_ctrl", vw, exp_vw());
  endtask

  task automatic rd_stat();
    logic [15:0] r;
    bus_op(1'b0, 1'b0, 16'h0, 2'b11, r);
    chk("status", 256'(r), 256'(exp_stat()));
  endtask

  task automatic rd_ctrl();
    logic [15:0] r;
    bus_op(1'b0, 1'b1, 16'h0, 2'b11, r);
    chk("hold_cnt", 256'(r), 256'(m_hold.size()));
  endtask

  task automatic host_ack();
    @(negedge clk);
    hack_in = m_strobe;
    m_hack  = m_strobe;
    repeat (5) @(posedge clk);
    #1;
    settle();
    chk("vw_hack", vw, exp_vw());
  endtask

  // Host ack lands so the push is accepted on the handover edge.
  task automatic push_on_handover(input byte unsigned b);
    @(negedge clk);
    hack_in = m_strobe;
    m_hack  = m_strobe;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.wb_we_i  = 1'b1;
    bus.wb_adr_i = 1'b0;
    bus.wb_dat_i = {8'h00, b};
    bus.wb_sel_i = 2'b01;
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    @(posedge clk);
    #1;
    chk("ack_ho", 256'(bus.wb_ack_o), 256'(1'b1));
    @(negedge clk);
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    @(posedge clk);
    #1;
    m_hold   = m_fill;
    m_fill.delete();
    m_fill.push_back(b);
    m_strobe = ~m_strobe;
    chk("vw_ho", vw, exp_vw());
  endtask

  initial begin
    logic [15:0] r;
    int op;
    bus.wb_dat_i = '0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 1'b0;
    bus.wb_sel_i = 2'b00;
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vw", vw, 256'd0);
    chk("rst_dat", 256'(bus.wb_dat_o), 256'd0);
    rst_n = 1'b1;
    rd_stat();

    push(8'h41, 2'b01);
    push(8'h42, 2'b11);
    push(8'h43, 2'b01);
    ctrl(16'h0001);
    chk("t2_cnt", 256'(vw[252:248]), 256'd3);
    chk("t2_dat", 256'(vw[23:0]), 256'h434241);
    chk("t2_stb", 256'(vw[255]), 256'd1);
    rd_stat();
    rd_ctrl();

    host_ack();
    rd_stat();
    for (int i = 0; i < 31; i++) push(byte'(i), 2'b01);
    chk("t3_cnt", 256'(vw[252:248]), 256'd31);
    chk("t3_stb", 256'(vw[255]), 256'd0);
    chk("t3_b30", 256'(vw[247:240]), 256'h1e);

    push(8'h77, 2'b10);
    for (int i = 0; i < 32; i++) push(byte'(8'h80 + i), 2'b01);
    rd_stat();
    chk("t4_ovf", 256'(exp_stat()), 256'(16'hdf00));
    ctrl(16'h0002);
    rd_stat();

    push_on_handover(8'ha5);
    rd_stat();
    rd_ctrl();

    host_ack();
    ctrl(16'h0001);
    host_ack();
    ctrl(16'h0001);
    rd_stat();
    chk("t6_stb", 256'(vw[255]), 256'(m_strobe));

    for (int n = 0; n < 400; n++) begin
      op = int'($urandom_range(0, 15));
      if (op < 9)
        push(byte'($urandom), 2'($urandom | 32'(op != 0)));
      else if (op == 9)
        ctrl(16'($urandom));
      else if (op < 12)
        rd_stat();
      else if (op == 12)
        rd_ctrl();
      else
        host_ack();
    end

    for (int i = 0; i < 5; i++) push(byte'(8'hc0 + i), 2'b01);
    ctrl(16'h0001);
    push(8'hee, 2'b01);
    rd_stat();
    @(negedge clk);
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = 1'b0;
    bus.wb_stb_i = 1'b1;
    bus.wb_cyc_i = 1'b1;
    @(posedge clk);
    #2;
    rst_n   = 1'b0;
    hack_in = 1'b0;
    #1;
    chk("mid_vw", vw, 256'd0);
    chk("mid_dat", 256'(bus.wb_dat_o), 256'd0);
    chk("mid_ack", 256'(bus.wb_ack_o), 256'd0);
    bus.wb_stb_i = 1'b0;
    bus.wb_cyc_i = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rd_stat();
    rd_ctrl();
    bus_op(1'b0, 1'b0, 16'h0, 2'b00, r);
    chk("post_rst", 256'(r), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
